// File: rtl/seq_restoring_divider_if.sv
// Request/response bundle for the sequential restoring divider.
// The requester drives start/operands and observes ready, done, results and flags.
interface seq_restoring_divider_if #(
  parameter int SW = 24
);
  logic              start_i;
  logic [2*SW-1:0]   Data_A_i;
  logic [SW-1:0]     Data_B_i;
  logic              ready_o;
  logic              done_o;
  logic [SW-1:0]     Quotient_o;
  logic [SW-1:0]     Remainder_o;
  logic              overflow_o;
  logic              div_by_zero_o;

  modport master (
    output start_i,
    output Data_A_i,
    output Data_B_i,
    input  ready_o,
    input  done_o,
    input  Quotient_o,
    input  Remainder_o,
    input  overflow_o,
    input  div_by_zero_o
  );

  modport slave (
    input  start_i,
    input  Data_A_i,
    input  Data_B_i,
    output ready_o,
    output done_o,
    output Quotient_o,
    output Remainder_o,
    output overflow_o,
    output div_by_zero_o
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Restoring divider: 2*SW-bit dividend / SW-bit divisor, one quotient bit per clock.
// Latency SW+2 clocks (2 on overflow/div-by-zero); start_i only taken while ready_o is high.
module seq_restoring_divider #(
  parameter int SW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = $clog2(SW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_n;

  logic [2*SW-1:0]  a_q, a_n;
  logic [SW-1:0]    b_q, b_n;
  logic [SW:0]      p_q, p_n;
  logic [SW-1:0]    l_q, l_n;
  logic [SW-1:0]    q_q, q_n;
  logic [CW-1:0]    cnt_q, cnt_n;

  logic [SW-1:0]    quo_q, quo_n;
  logic [SW-1:0]    rem_q, rem_n;
  logic             ovf_q, ovf_n;
  logic             dbz_q, dbz_n;
  logic             done_q, done_n;
  logic             ready_q, ready_n;

  logic             accept;
  logic [SW:0]      trial;
  logic [SW:0]      diff;
  logic             qbit;

  assign bus.ready_o       = ready_q;
  assign bus.done_o        = done_q;
  assign bus.Quotient_o    = quo_q;
  assign bus.Remainder_o   = rem_q;
  assign bus.overflow_o    = ovf_q;
  assign bus.div_by_zero_o = dbz_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      l_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      p_q     <= p_n;
      l_q     <= l_n;
      q_q     <= q_n;
      cnt_q   <= cnt_n;
      quo_q   <= quo_n;
      rem_q   <= rem_n;
      ovf_q   <= ovf_n;
      dbz_q   <= dbz_n;
      done_q  <= done_n;
      ready_q <= ready_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    p_n     = p_q;
    l_n     = l_q;
    q_n     = q_q;
    cnt_n   = cnt_q;
    quo_n   = quo_q;
    rem_n   = rem_q;
    ovf_n   = ovf_q;
    dbz_n   = dbz_q;

    accept = bus.start_i && ready_q;
    // P < B always holds, so P[SW] is zero and the shifted trial never loses a bit.
    trial  = {p_q[SW-1:0], l_q[SW-1]};
    diff   = trial - {1'b0, b_q};
    qbit   = (trial >= {1'b0, b_q});

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_n     = bus.Data_A_i;
          b_n     = bus.Data_B_i;
          state_n = S_CHECK;
        end else if (state_q == S_DONE) begin
          state_n = S_IDLE;
        end
      end

      S_CHECK: begin
        q_n = '0;
        if (b_q == '0) begin
          dbz_n   = 1'b1;
          ovf_n   = 1'b0;
          quo_n   = '1;
          rem_n   = a_q[SW-1:0];
          state_n = S_DONE;
        end else if (a_q[2*SW-1:SW] >= b_q) begin
          dbz_n   = 1'b0;
          ovf_n   = 1'b1;
          quo_n   = '1;
          rem_n   = '0;
          state_n = S_DONE;
        end else begin
          p_n     = {1'b0, a_q[2*SW-1:SW]};
          l_n     = a_q[SW-1:0];
          cnt_n   = CW'(SW - 1);
          state_n = S_ITER;
        end
      end

      S_ITER: begin
        l_n = {l_q[SW-2:0], 1'b0};
        p_n = qbit ? diff : trial;
        q_n = {q_q[SW-2:0], qbit};
        if (cnt_q == '0) begin
          quo_n   = q_n;
          rem_n   = p_n[SW-1:0];
          ovf_n   = 1'b0;
          dbz_n   = 1'b0;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    done_n  = (state_n == S_DONE);
    ready_n = (state_n == S_IDLE) || (state_n == S_DONE);
  end

endmodule
